// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Contents: FSM state enum, NOP encoding, default opcode-word immediate-flag bit.
package fetch_pkg;

   typedef enum logic {
      S_OP  = 1'b0,
      S_IMM = 1'b1
   } fetch_state_e;

   // NOP is all zeros; sized wide enough to be cast down to any word width
   localparam logic [63:0] NOP_WORD = 64'h0;

   localparam int unsigned IMM_FLAG_BIT_DEFAULT = 0;

endpackage : fetch_pkg

// File: rtl/if_id_register.sv
// IF/ID pipeline payload register.
// Ports: clk, reset (sync, active-high); load captures the *_d payload with valid=1;
// bubble drops valid only; clear drops valid and zeroes instr/imm (pc fields keep
// their last value). clear beats load/bubble; with none asserted the register holds.
module if_id_register
   import fetch_pkg::*;
#(
   parameter int unsigned INSTR_W = 16,
   parameter int unsigned ADDR_W  = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               bubble,
   input  logic               clear,
   input  logic [INSTR_W-1:0] instr_d,
   input  logic [INSTR_W-1:0] imm_d,
   input  logic [ADDR_W-1:0]  pc_d,
   input  logic [ADDR_W-1:0]  next_pc_d,
   output logic               valid,
   output logic [INSTR_W-1:0] instr,
   output logic [INSTR_W-1:0] imm,
   output logic [ADDR_W-1:0]  pc,
   output logic [ADDR_W-1:0]  next_pc
);

   // Payload register with clear > load > bubble > hold priority
   always_ff @(posedge clk) begin
      if (reset) begin
         valid   <= 1'b0;
         instr   <= INSTR_W'(NOP_WORD);
         imm     <= '0;
         pc      <= '0;
         next_pc <= '0;
      end else if (clear) begin
         valid <= 1'b0;
         instr <= INSTR_W'(NOP_WORD);
         imm   <= '0;
      end else if (load) begin
         valid   <= 1'b1;
         instr   <= instr_d;
         imm     <= imm_d;
         pc      <= pc_d;
         next_pc <= next_pc_d;
      end else if (bubble) begin
         valid <= 1'b0;
      end
   end

endmodule : if_id_register

// File: rtl/instr_fetch_stage.sv
// Instruction-fetch stage: drives the instruction-memory address from the PC and
// assembles one- or two-word (opcode + immediate) instructions into IF/ID.
// Ports: clk, reset (sync, active-high), pc_in, imem_addr (comb copy of pc_in),
// imem_data (async-read word), stall, flush, if_id_* (IF/ID payload), fetch_busy.
// Build option: define FETCH_IMM_EN to enable two-word instructions; otherwise every
// word issues as a one-word instruction and if_id_imm/fetch_busy stay 0.
module instr_fetch_stage
   import fetch_pkg::*;
#(
   parameter int unsigned INSTR_W      = 16,
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned IMM_FLAG_BIT = IMM_FLAG_BIT_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  pc_in,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic               stall,
   input  logic               flush,
   output logic               if_id_valid,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic [INSTR_W-1:0] if_id_imm,
   output logic [ADDR_W-1:0]  if_id_pc,
   output logic [ADDR_W-1:0]  if_id_next_pc,
   output logic               fetch_busy
);

   if (IMM_FLAG_BIT >= INSTR_W) begin : g_flag_range
      $error("IMM_FLAG_BIT must index a bit of the instruction word");
   end

   fetch_state_e       state, state_next;
   logic               reg_load, reg_bubble, reg_clear;
   logic [INSTR_W-1:0] ld_instr, ld_imm;
   logic [ADDR_W-1:0]  ld_pc, ld_next_pc;

`ifdef FETCH_IMM_EN
   logic [INSTR_W-1:0] hold_instr;
   logic [ADDR_W-1:0]  hold_pc;
   logic               hold_load;
`endif

   assign imem_addr  = pc_in;
   // The instruction always ends at the word currently presented, so next_pc tracks pc_in
   assign ld_next_pc = ADDR_W'(pc_in + ADDR_W'(1));

   // State register; fetch_busy is registered alongside it
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_OP;
         fetch_busy <= 1'b0;
      end else begin
         state      <= state_next;
         fetch_busy <= (state_next == S_IMM);
      end
   end

`ifdef FETCH_IMM_EN
   // Opcode word and its address, kept while the immediate is fetched
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_instr <= INSTR_W'(NOP_WORD);
         hold_pc    <= '0;
      end else if (hold_load) begin
         hold_instr <= imem_data;
         hold_pc    <= pc_in;
      end
   end
`endif

   // Next-state and IF/ID control; flush outranks stall
   always_comb begin
      state_next = state;
      reg_load   = 1'b0;
      reg_bubble = 1'b0;
      reg_clear  = 1'b0;
      ld_instr   = imem_data;
      ld_imm     = '0;
      ld_pc      = pc_in;
`ifdef FETCH_IMM_EN
      hold_load  = 1'b0;
`endif
      if (flush) begin
         reg_clear  = 1'b1;
         state_next = S_OP;
      end else if (!stall) begin
         case (state)
            S_OP: begin
`ifdef FETCH_IMM_EN
               hold_load = 1'b1;
               if (imem_data[IMM_FLAG_BIT]) begin
                  reg_bubble = 1'b1;
                  state_next = S_IMM;
               end else begin
                  reg_load = 1'b1;
               end
`else
               reg_load = 1'b1;
`endif
            end
            S_IMM: begin
`ifdef FETCH_IMM_EN
               reg_load = 1'b1;
               ld_instr = hold_instr;
               ld_imm   = imem_data;
               ld_pc    = hold_pc;
`endif
               state_next = S_OP;
            end
            default: state_next = S_OP;
         endcase
      end
   end

   if_id_register #(
      .INSTR_W (INSTR_W),
      .ADDR_W  (ADDR_W)
   ) u_if_id (
      .clk       (clk),
      .reset     (reset),
      .load      (reg_load),
      .bubble    (reg_bubble),
      .clear     (reg_clear),
      .instr_d   (ld_instr),
      .imm_d     (ld_imm),
      .pc_d      (ld_pc),
      .next_pc_d (ld_next_pc),
      .valid     (if_id_valid),
      .instr     (if_id_instr),
      .imm       (if_id_imm),
      .pc        (if_id_pc),
      .next_pc   (if_id_next_pc)
   );

endmodule : instr_fetch_stage

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage; follows the FETCH_IMM_EN build option.
module tb_instr_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_in;
   logic [31:0] imem_addr;
   logic [15:0] imem_data;
   logic        stall, flush;
   logic        if_id_valid;
   logic [15:0] if_id_instr, if_id_imm;
   logic [31:0] if_id_pc, if_id_next_pc;
   logic        fetch_busy;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   instr_fetch_stage dut (
      .clk           (clk),
      .reset         (reset),
      .pc_in         (pc_in),
      .imem_addr     (imem_addr),
      .imem_data     (imem_data),
      .stall         (stall),
      .flush         (flush),
      .if_id_valid   (if_id_valid),
      .if_id_instr   (if_id_instr),
      .if_id_imm     (if_id_imm),
      .if_id_pc      (if_id_pc),
      .if_id_next_pc (if_id_next_pc),
      .fetch_busy    (fetch_busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] pc, input logic [15:0] data);
      pc_in     = pc;
      imem_data = data;
   endtask

   task automatic check_word(input string tag, input logic [15:0] instr, input logic [15:0] imm,
                             input logic [31:0] pc, input logic [31:0] npc);
      check({tag, ".valid"},   32'(if_id_valid), 32'd1);
      check({tag, ".instr"},   32'(if_id_instr), 32'(instr));
      check({tag, ".imm"},     32'(if_id_imm),   32'(imm));
      check({tag, ".pc"},      if_id_pc,         pc);
      check({tag, ".next_pc"}, if_id_next_pc,    npc);
      check({tag, ".busy"},    32'(fetch_busy),  32'd0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".valid"},   32'(if_id_valid), 32'd0);
      check({tag, ".instr"},   32'(if_id_instr), 32'd0);
      check({tag, ".imm"},     32'(if_id_imm),   32'd0);
      check({tag, ".pc"},      if_id_pc,         32'd0);
      check({tag, ".next_pc"}, if_id_next_pc,    32'd0);
      check({tag, ".busy"},    32'(fetch_busy),  32'd0);
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      drive(32'h0, 16'h0);
      step(); step();
      check_zero("reset");
      reset = 1'b0;

      // imem_addr follows pc_in combinationally
      drive(32'h20, 16'h1234);
      #1;
      check("imem_addr", imem_addr, 32'h20);
      step();
      check_word("one_word", 16'h1234, 16'h0, 32'h20, 32'h21);

      // Flagged opcode
      drive(32'h20, 16'h0001);
      step();
`ifdef FETCH_IMM_EN
      check("two_word.bubble_valid", 32'(if_id_valid), 32'd0);
      check("two_word.bubble_busy",  32'(fetch_busy),  32'd1);
      drive(32'h21, 16'hBEEF);
      step();
      check_word("two_word", 16'h0001, 16'hBEEF, 32'h20, 32'h22);

      // Stall three cycles in S_IMM, immediate taken from the held PC afterwards
      drive(32'h30, 16'h0003);
      step();
      check("stall_imm.enter_busy", 32'(fetch_busy), 32'd1);
      stall = 1'b1;
      drive(32'h31, 16'h5555);
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_imm.valid", 32'(if_id_valid), 32'd0);
         check("stall_imm.busy",  32'(fetch_busy),  32'd1);
         check("stall_imm.instr", 32'(if_id_instr), 32'h0001);
      end
      stall = 1'b0;
      drive(32'h31, 16'hCAFE);
      step();
      check_word("stall_imm.release", 16'h0003, 16'hCAFE, 32'h30, 32'h32);

      // Flush during S_IMM drops the held opcode
      drive(32'h40, 16'h0005);
      step();
      check("flush_imm.enter_busy", 32'(fetch_busy), 32'd1);
      flush = 1'b1;
      drive(32'h0, 16'h7777);
      step();
      flush = 1'b0;
      check("flush_imm.valid", 32'(if_id_valid), 32'd0);
      check("flush_imm.instr", 32'(if_id_instr), 32'd0);
      check("flush_imm.imm",   32'(if_id_imm),   32'd0);
      check("flush_imm.busy",  32'(fetch_busy),  32'd0);
      drive(32'h0, 16'h1110);
      step();
      check_word("after_flush", 16'h1110, 16'h0, 32'h0, 32'h1);
`else
      check_word("flag_one_word", 16'h0001, 16'h0, 32'h20, 32'h21);
`endif

      // Stall in S_OP freezes the loaded instruction
      drive(32'h60, 16'h4444);
      step();
      check_word("pre_stall", 16'h4444, 16'h0, 32'h60, 32'h61);
      stall = 1'b1;
      drive(32'h61, 16'h8888);
      step(); step();
      check_word("stall_op", 16'h4444, 16'h0, 32'h60, 32'h61);

      // Flush together with stall: flush wins
      flush = 1'b1;
      step();
      check("flush_stall.valid", 32'(if_id_valid), 32'd0);
      check("flush_stall.instr", 32'(if_id_instr), 32'd0);
      flush = 1'b0; stall = 1'b0;

      // Reset while an immediate is pending (or flagged word in the one-word build)
      drive(32'h50, 16'h0007);
      step();
`ifdef FETCH_IMM_EN
      check("reset_imm.busy_before", 32'(fetch_busy), 32'd1);
      reset = 1'b1;
      drive(32'h51, 16'h9999);
      step();
      check_zero("reset_imm");
      reset = 1'b0;
`else
      check_word("flag7_one_word", 16'h0007, 16'h0, 32'h50, 32'h51);
`endif

      // next_pc wraps at the top of the address space
      drive(32'hFFFF_FFFF, 16'h2222);
      step();
      check_word("wrap", 16'h2222, 16'h0, 32'hFFFF_FFFF, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_instr_fetch_stage

// File: doc/instr_fetch_stage.md
# instr_fetch_stage

Instruction-fetch stage that sits directly downstream of the program counter. It presents the current PC to the word-addressed instruction memory and assembles one- or two-word (opcode + 16-bit immediate) instructions. It loads the IF/ID pipeline register consumed by decode, and supports stall, flush and pipeline-bubble insertion.

## Interface
Parameters:
- INSTR_W, 16, instruction-memory word width.
- ADDR_W, 32, PC/address width.
- IMM_FLAG_BIT, 0, bit of the opcode word marking a two-word instruction.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- pc_in  in  ADDR_W  current PC from the program counter.
- imem_addr  out  ADDR_W  combinational copy of pc_in.
- imem_data  in  INSTR_W  instruction word at imem_addr, same cycle (asynchronous read).
- stall  in  1  hold the stage; the same signal stalls the PC.
- flush  in  1  discard in-flight and held contents (branch, interrupt, or return redirect).
- if_id_valid  out  1  IF/ID holds a complete instruction.
- if_id_instr  out  INSTR_W  opcode word.
- if_id_imm  out  INSTR_W  immediate word; 0 for one-word instructions.
- if_id_pc  out  ADDR_W  address of the opcode word.
- if_id_next_pc  out  ADDR_W  address following the instruction; used as the return address for CALL and INT.
- fetch_busy  out  1  high in S_IMM (opcode held, immediate pending).

## Operation
- FSM states: S_OP and S_IMM. Reset state is S_OP.
- **S_OP**, no stall, no flush: capture imem_data into hold_instr and pc_in into hold_pc.
  - If imem_data[IMM_FLAG_BIT]=1: go to S_IMM and clear if_id_valid (bubble).
  - Otherwise: load IF/ID with instr=imem_data, imm=0, pc=pc_in, next_pc=pc_in+1, valid=1.
- **S_IMM**, no stall, no flush: load IF/ID with instr=hold_instr, imm=imem_data, pc=hold_pc, next_pc=pc_in+1, valid=1, then return to S_OP.
- **stall**=1 and flush=0: state, hold registers and all IF/ID outputs are unchanged.
- **flush**=1: if_id_valid←0, if_id_instr/imm←0, state←S_OP, held opcode dropped. flush has priority over stall.
- **reset**: all outputs 0 and state S_OP. reset has priority over flush and stall, and aborts S_IMM with no partial instruction emitted.
- Address arithmetic is modulo 2^ADDR_W. pc_in=32'hFFFF_FFFF gives next_pc=0.

## Timing
- imem_addr = pc_in with zero latency.
- One-word instruction: appears in IF/ID on the edge after the cycle its PC is presented (1-cycle latency).
- Two-word instruction: appears in IF/ID 2 edges after the opcode PC, preceded by exactly one bubble cycle.
- An interrupt redirect (PC←0) must assert flush in the same cycle, so the word fetched before the redirect is never issued.
- Outputs after reset: if_id_valid=0, if_id_instr=0, if_id_imm=0, if_id_pc=0, if_id_next_pc=0, fetch_busy=0.

## Configuration
- Macro: FETCH_IMM_EN.
- Defined: two-word handling as described.
- Undefined: S_IMM is never entered. Every word is a one-word instruction, if_id_imm is tied to 0, fetch_busy to 0, and IMM_FLAG_BIT is ignored.

## Structure
- Shared package fetch_pkg holds:
  - the FSM state enum (S_OP, S_IMM);
  - the NOP encoding (all zeros);
  - the IMM_FLAG_BIT default.
- One sub-module is natural: if_id_register, the IF/ID payload register with load, hold and clear controls driven by the FSM.

## Test plan
- Reset, then pc_in=0x20 with imem_data=0x1234 (flag 0) → next edge: valid=1, instr=0x1234, imm=0, pc=0x20, next_pc=0x21.
- pc_in=0x20 with imem_data=0x0001, then pc_in=0x21 with imem_data=0xBEEF → bubble on edge 1; edge 2: instr=0x0001, imm=0xBEEF, pc=0x20, next_pc=0x22.
- stall=1 for 3 cycles during S_IMM → outputs and state frozen. After release, imm is captured from the stable pc_in=0x21.
- flush during S_IMM → valid=0 and state=S_OP next edge. A subsequent pc_in=0x0 word is fetched as a new opcode.
- flush and stall both high → flush wins, valid=0.
- reset asserted mid-S_IMM → all outputs 0 and fetch_busy=0 on the next edge. With FETCH_IMM_EN undefined, 0x0001 issues as a one-word instruction with imm=0.
